// File: rtl/reproductor_melodia_pkg.sv
// Shared definitions for the melody player.
// Contents: the FSM state encoding, the default parameter values, and the
// index, accumulator and duration-counter width constants.
package reproductor_melodia_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARGA = 2'd1,
        SONAR = 2'd2,
        PAUSA = 2'd3
    } estado_t;

    localparam int CLK_HZ_DEF     = 50_000_000;
    localparam int NUM_NOTAS_DEF  = 25;
    localparam int DUR_CICLOS_DEF = 12_500_000;
    localparam int GAP_CICLOS_DEF = 2_500_000;

    // Note index width. It covers up to 32 table entries.
    localparam int IDX_W = 5;
    // Phase accumulator width is clog2(CLK_HZ)+1. This leaves headroom for
    // acc + 2*65535 before the wrap subtraction.
    localparam int ACC_W = $clog2(CLK_HZ_DEF) + 1;
    // Duration counter width. It holds DUR_CICLOS-1 and GAP_CICLOS-1.
    localparam int CNT_W = 24;

endpackage

// File: rtl/reproductor_melodia_generador_tono.sv
// generador_tono: a phase-accumulator square-wave generator.
// Each enabled cycle, the accumulator adds 2*frec. When the sum reaches
// CLK_HZ, the generator wraps the accumulator and toggles audio. As a result,
// audio completes frec full periods per second.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : advance the accumulator this cycle
//   clr        : clear the accumulator and audio (has priority over en)
//   frec[15:0] : tone frequency in Hz (0 holds audio low)
//   audio      : square-wave output
module generador_tono
    import reproductor_melodia_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] frec,
    output logic        audio
);

    localparam logic [ACC_W-1:0] MODULO = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] suma;

    assign suma = acc + ACC_W'({frec, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            audio <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            audio <= 1'b0;
        end else if (en) begin
            // acc always stays below MODULO, so a single subtraction is
            // enough to wrap it. No divider is needed.
            if (suma >= MODULO) begin
                acc   <= suma - MODULO;
                audio <= ~audio;
            end else begin
                acc <= suma;
            end
        end
    end

endmodule

// File: rtl/reproductor_melodia.sv
// reproductor_melodia: plays NUM_NOTAS entries from an external note table.
// Each note takes 1 load cycle, then DUR_CICLOS sounding cycles, then
// GAP_CICLOS silent cycles.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   start           : begin playback from index 0 (honoured only in IDLE)
//   stop            : abort playback and return to IDLE on the next edge
//   nota_idx[4:0]   : index sent to the external note table
//   nota_hz[15:0]   : frequency returned by the table (0 = rest)
//   audio           : square-wave output (low outside SONAR)
//   busy            : high in every state except IDLE
//   fin             : one-cycle pulse after the last note completes normally
//   estado_dbg[1:0] : current FSM state, for observation
// Handshake: start is a level sampled on a rising edge while busy=0. No
// acknowledgement is given apart from busy rising on the following cycle.
module reproductor_melodia
    import reproductor_melodia_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int NUM_NOTAS  = NUM_NOTAS_DEF,
    parameter int DUR_CICLOS = DUR_CICLOS_DEF,
    parameter int GAP_CICLOS = GAP_CICLOS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic [4:0]  nota_idx,
    input  logic [15:0] nota_hz,
    output logic        audio,
    output logic        busy,
    output logic        fin,
    output logic [1:0]  estado_dbg
);

    localparam logic [CNT_W-1:0] DUR_M1 = CNT_W'(DUR_CICLOS - 1);
    localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CICLOS - 1);
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_NOTAS - 1);

    estado_t          estado;
    estado_t          estado_sig;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      nota_reg;
    logic             cnt_cero;
    logic             ultima;
    logic             gen_en;
    logic             gen_clr;
    logic             tono;

    assign cnt_cero = (cnt == '0);
    assign ultima   = (nota_idx == ULTIMO);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    // Next-state logic. stop overrides every other transition.
    always_comb begin
        estado_sig = estado;
        if (stop) begin
            estado_sig = IDLE;
        end else begin
            case (estado)
                IDLE:    if (start) estado_sig = CARGA;
                CARGA:   estado_sig = SONAR;
                SONAR:   if (cnt_cero) estado_sig = PAUSA;
                PAUSA:   if (cnt_cero) estado_sig = ultima ? IDLE : CARGA;
                default: estado_sig = IDLE;
            endcase
        end
    end

    // Outputs derived from the state
    always_comb begin
        busy       = (estado != IDLE);
        gen_en     = (estado == SONAR);
        gen_clr    = (estado == CARGA) || stop;
        // Gating by state keeps the line silent in PAUSA and IDLE, even if the
        // generator's last toggle left it high.
        audio      = tono && (estado == SONAR);
        estado_dbg = estado;
    end

    // Datapath: note index, latched frequency, duration counter, fin pulse.
    // The counter is loaded with N-1 so that each state lasts exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nota_idx <= '0;
            nota_reg <= '0;
            cnt      <= '0;
            fin      <= 1'b0;
        end else begin
            fin <= 1'b0;
            if (stop) begin
                nota_idx <= '0;
                cnt      <= '0;
            end else begin
                case (estado)
                    IDLE: nota_idx <= '0;
                    CARGA: begin
                        nota_reg <= nota_hz;
                        cnt      <= DUR_M1;
                    end
                    SONAR: cnt <= cnt_cero ? GAP_M1 : cnt - CNT_W'(1);
                    PAUSA: begin
                        if (cnt_cero) begin
                            if (ultima) begin
                                fin      <= 1'b1;
                                nota_idx <= '0;
                            end else begin
                                nota_idx <= nota_idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    generador_tono #(
        .CLK_HZ (CLK_HZ)
    ) u_tono (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (gen_en),
        .clr   (gen_clr),
        .frec  (nota_reg),
        .audio (tono)
    );

endmodule

// File: tb/tb_reproductor_melodia.sv
// Bench for reproductor_melodia with CLK_HZ=1000, NUM_NOTAS=3, DUR=20, GAP=4.
// The note table holds {250, 0, 125}. A driver steps one clock cycle per call
// and queues the outputs expected after that edge. A monitor pops one entry
// and compares it on each falling edge.
module tb_reproductor_melodia;

    localparam int TB_CLK_HZ = 1000;
    localparam int NOTAS     = 3;
    localparam int DUR       = 20;
    localparam int GAP       = 4;
    localparam int PERIODO   = 1 + DUR + GAP;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [4:0]  nota_idx;
    logic [15:0] nota_hz;
    logic        audio;
    logic        busy;
    logic        fin;
    logic [1:0]  estado_dbg;
    logic        hz_corrupt;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks;
    int         n_fail;
    event       mon_ev;

    logic [7:0] mon_exp;
    logic [7:0] mon_got;
    string      mon_nm;

    reproductor_melodia #(
        .CLK_HZ     (TB_CLK_HZ),
        .NUM_NOTAS  (NOTAS),
        .DUR_CICLOS (DUR),
        .GAP_CICLOS (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .nota_idx   (nota_idx),
        .nota_hz    (nota_hz),
        .audio      (audio),
        .busy       (busy),
        .fin        (fin),
        .estado_dbg (estado_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hz_of(input int i);
        case (i)
            0:       return 250;
            1:       return 0;
            2:       return 125;
            default: return 0;
        endcase
    endfunction

    // External note table. hz_corrupt drives a foreign value while a note
    // is sounding.
    assign nota_hz = hz_corrupt ? 16'd333 : 16'(hz_of(int'(nota_idx)));

    function automatic logic [7:0] vec(input logic b, input logic f, input int idx, input logic a);
        logic [4:0] i5;
        i5 = idx[4:0];
        return {b, f, i5, a};
    endfunction

    // driver: drive inputs for the current cycle, clock once, queue expectation
    task automatic cyc(input logic s, input logic sp, input logic cr, input logic [7:0] e, input string nm);
        start      = s;
        stop       = sp;
        hz_corrupt = cr;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Plays the melody from IDLE. Post-edge cycle c is numbered from the CARGA
    // of note 0. stop_at is the cycle where stop is asserted (-1 for none).
    // cut_at ends the task early after that cycle. disturb re-pulses start and
    // corrupts the table during SONAR.
    task automatic play(input int stop_at, input int cut_at, input bit disturb);
        int n, p, k, f, pc;
        logic s, cr, a;
        logic [7:0] e;
        string nm;
        for (int c = 0; c <= NOTAS * PERIODO + 1; c++) begin
            pc = c - 1;
            s  = (c == 0);
            cr = 1'b0;
            if (disturb && pc >= 0 && pc < NOTAS * PERIODO &&
                (pc % PERIODO) >= 1 && (pc % PERIODO) <= DUR) begin
                s  = 1'b1;
                cr = 1'b1;
            end
            if (pc == stop_at) begin
                cyc(1'b0, 1'b1, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "stop");
                cyc(1'b0, 1'b0, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "after_stop");
                return;
            end
            if (c < NOTAS * PERIODO) begin
                n = c / PERIODO;
                p = c % PERIODO;
                f = hz_of(n);
                if (p == 0) begin
                    e  = vec(1'b1, 1'b0, n, 1'b0);
                    nm = "carga";
                end else if (p <= DUR) begin
                    k  = p - 1;
                    a  = (((k * 2 * f) / TB_CLK_HZ) % 2) == 1;
                    e  = vec(1'b1, 1'b0, n, a);
                    nm = "sonar";
                end else begin
                    e  = vec(1'b1, 1'b0, n, 1'b0);
                    nm = "pausa";
                end
            end else if (c == NOTAS * PERIODO) begin
                e  = vec(1'b0, 1'b1, 0, 1'b0);
                nm = "fin";
            end else begin
                e  = vec(1'b0, 1'b0, 0, 1'b0);
                nm = "idle_after_fin";
            end
            cyc(s, 1'b0, cr, e, nm);
            if (c == cut_at) return;
        end
    endtask

    // Pulls reset low between edges. The outputs are checked before any
    // further clock edge occurs.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(vec(1'b0, 1'b0, 0, 1'b0));
        name_q.push_back("rst_async");
        #2;
        -> mon_ev;
        @(posedge clk);
        #1;
        exp_q.push_back(vec(1'b0, 1'b0, 0, 1'b0));
        name_q.push_back("rst_hold");
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "idle_after_rst");
    endtask

    // scoreboard monitor
    always begin
        @(negedge clk or mon_ev);
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_got = {busy, fin, nota_idx, audio};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got busy=%0b fin=%0b idx=%0d audio=%0b, expected busy=%0b fin=%0b idx=%0d audio=%0b",
                         mon_nm, $time, mon_got[7], mon_got[6], mon_got[5:1], mon_got[0],
                         mon_exp[7], mon_exp[6], mon_exp[5:1], mon_exp[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        hz_corrupt = 1'b0;

        @(posedge clk);
        #1;
        exp_q.push_back(vec(1'b0, 1'b0, 0, 1'b0));
        name_q.push_back("reset");
        #1;
        rst_n = 1'b1;

        cyc(1'b0, 1'b0, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "idle");
        cyc(1'b1, 1'b1, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "start_and_stop");
        cyc(1'b0, 1'b0, 1'b0, vec(1'b0, 1'b0, 0, 1'b0), "idle2");

        play(-1, -1, 1'b0);                 // full melody
        play(-1, -1, 1'b1);                 // start re-pulsed, table disturbed
        play(PERIODO + 1 + 10, -1, 1'b0);   // stop at SONAR cycle 10 of note 1
        play(-1, 1 + DUR + 1, 1'b0);        // run into note 0 PAUSA
        async_reset();
        play(-1, -1, 1'b0);                 // replay from index 0

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
